sending_fsm: RTL and testbench

- Serialises a 256-bit elliptic-curve result (curve_out) into sixteen 16-bit words and writes them into the outgoing-packet record buffer (the "to B" buffer), addresses 0..15.
- After writing, waits for the remote side's packet header to arrive, then raises done.
- Sits between the curve arithmetic core (curve_done/curve_out) and the packet transmit buffer/receiver in the phone datapath.

---
 rtl/sending_fsm.sv | 128 ++++++++++++
 tb/tb_sending_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sending_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sending_fsm
// Purpose  : Serialises a 256-bit curve result into sixteen 16-bit words,
//            writes them MSW-first into record buffer addresses 0..15, then
//            waits for the peer's packet header before raising done.
// Revision : 1.0  initial release
// ============================================================================
module sending_fsm (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] curve_out,
  input  logic         curve_done,
  input  logic [15:0]  incoming_packet_header,
  output logic         recordingToB,
  output logic [3:0]   recordAddr,
  output logic [15:0]  recordData,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_HDR = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     count;
  logic [3:0]     count_nxt;
  logic [3:0]     next_idx;
  logic [255:0]   shadow;
  logic [255:0]   shadow_nxt;
  logic           write_nxt;
  logic [3:0]     addr_nxt;
  logic [15:0]    data_nxt;
  logic           done_nxt;

  // State register; reset aborts any in-flight write immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers, so no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count        <= 4'd0;
      shadow       <= 256'd0;
      recordingToB <= 1'b0;
      recordAddr   <= 4'd0;
      recordData   <= 16'd0;
      done         <= 1'b0;
    end else begin
      count        <= count_nxt;
      shadow       <= shadow_nxt;
      recordingToB <= write_nxt;
      recordAddr   <= addr_nxt;
      recordData   <= data_nxt;
      done         <= done_nxt;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead and then registered.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    shadow_nxt = shadow;
    write_nxt  = 1'b0;
    addr_nxt   = 4'd0;
    data_nxt   = 16'd0;
    done_nxt   = 1'b0;
    next_idx   = count + 4'd1;

    case (state)
      IDLE: begin
        if (curve_done) begin
          // Word 0 comes straight from the input so it appears on the very
          // next cycle; later words come from the latched copy.
          shadow_nxt = curve_out;
          count_nxt  = 4'd0;
          state_nxt  = WRITE;
          write_nxt  = 1'b1;
          addr_nxt   = 4'd0;
          data_nxt   = curve_out[255:240];
        end
      end

      WRITE: begin
        if (count == 4'd15) begin
          count_nxt = 4'd0;
          state_nxt = WAIT_HDR;
        end else begin
          count_nxt = next_idx;
          write_nxt = 1'b1;
          addr_nxt  = next_idx;
          // Word k lives at bit offset 16*(15-k); 15-k is ~k on four bits.
          data_nxt  = shadow[{~next_idx, 4'b0000} +: 16];
        end
      end

      WAIT_HDR: begin
        if (incoming_packet_header != 16'd0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end

      DONE: begin
        if (curve_done) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sending_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_sending_fsm
// Purpose  : Randomised self-checking bench for sending_fsm; expectations are
//            derived from the transaction rules (word k = value >> 16*(15-k)).
// Revision : 1.0  initial release
// ============================================================================
module tb_sending_fsm;

  logic         clock = 1'b0;
  logic         reset;
  logic [255:0] curve_out;
  logic         curve_done;
  logic [15:0]  incoming_packet_header;
  logic         recordingToB;
  logic [3:0]   recordAddr;
  logic [15:0]  recordData;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  sending_fsm dut (
    .clock                  (clock),
    .reset                  (reset),
    .curve_out              (curve_out),
    .curve_done             (curve_done),
    .incoming_packet_header (incoming_packet_header),
    .recordingToB           (recordingToB),
    .recordAddr             (recordAddr),
    .recordData             (recordData),
    .done                   (done)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [15:0] word_of(input logic [255:0] v, input int k);
    logic [255:0] s;
    s = v >> (16 * (15 - k));
    return s[15:0];
  endfunction

  task automatic chk_quiet(input string tag, input logic exp_done);
    chk({tag, ".we"},   32'(recordingToB), 32'd0);
    chk({tag, ".addr"}, 32'(recordAddr),   32'd0);
    chk({tag, ".data"}, 32'(recordData),   32'd0);
    chk({tag, ".done"}, 32'(done),         32'(exp_done));
  endtask

  // Expect sixteen consecutive words of v, then the write strobe dropping.
  task automatic expect_write(input logic [255:0] v, input bit scramble);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("wr.we",   32'(recordingToB), 32'd1);
      chk("wr.addr", 32'(recordAddr),   32'(k));
      chk("wr.data", 32'(recordData),   32'(word_of(v, k)));
      chk("wr.done", 32'(done),         32'd0);
      if (scramble) curve_out = rand256();
    end
    tick();
    chk_quiet("wr.end", 1'b0);
  endtask

  // Header wait, done hold, and return to idle.
  task automatic finish_txn(input bit hdr_preset, input int hdr_delay);
    if (!hdr_preset) begin
      for (int i = 0; i < hdr_delay; i++) begin
        tick();
        chk_quiet("hdr.wait", 1'b0);
      end
      incoming_packet_header = 16'($urandom_range(1, 65535));
    end
    tick();
    chk_quiet("hdr.done", 1'b1);
    for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
      incoming_packet_header = 16'($urandom());
      tick();
      chk_quiet("done.hold", 1'b1);
    end
    curve_done = 1'b0;
    tick();
    chk_quiet("done.drop", 1'b0);
    incoming_packet_header = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("idle", 1'b0);
    end
  endtask

  task automatic run_txn(input logic [255:0] v, input bit scramble,
                         input bit hdr_preset, input int hdr_delay);
    if (hdr_preset) begin
      incoming_packet_header = 16'($urandom_range(1, 65535));
      tick();
      chk_quiet("idle.hdr", 1'b0);
    end
    curve_out  = v;
    curve_done = 1'b1;
    expect_write(v, scramble);
    finish_txn(hdr_preset, hdr_delay);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [255:0] v;
    reset                  = 1'b1;
    curve_done             = 1'b0;
    curve_out              = '0;
    incoming_packet_header = 16'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset", 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("post.reset", 1'b0);
    end

    // Alternating-bit pattern, header held at zero for ten cycles.
    v = {16{16'h5555}};
    run_txn(v, 1'b0, 1'b0, 10);

    // Descending word values confirm MSW-first ordering; input scrambled mid-write.
    v = '0;
    for (int k = 0; k < 16; k++) v = {v[239:0], 16'(15 - k)};
    run_txn(v, 1'b1, 1'b0, 4);

    // Header already nonzero before the request: full write still happens.
    incoming_packet_header = 16'h0001;
    tick();
    chk_quiet("idle.hdr1", 1'b0);
    curve_out  = v;
    curve_done = 1'b1;
    expect_write(v, 1'b0);
    finish_txn(1'b1, 0);

    // Randomised transactions.
    for (int t = 0; t < 8; t++) begin
      run_txn(rand256(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 12)));
    end

    // Asynchronous reset in the middle of the write at word 7.
    v          = rand256();
    curve_out  = v;
    curve_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rst.wr.addr", 32'(recordAddr), 32'(k));
      chk("rst.wr.data", 32'(recordData), 32'(word_of(v, k)));
    end
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("rst.async", 1'b0);
    tick();
    chk_quiet("rst.held", 1'b0);
    reset = 1'b0;
    v         = rand256();
    curve_out = v;
    expect_write(v, 1'b0);
    finish_txn(1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
